// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester and I2C-master signals of the bus arbiter
interface i2c_bus_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   lock;
    logic [7*N_REQ-1:0] dev_addr_in;
    logic [8*N_REQ-1:0] wdata_in;
    logic [N_REQ-1:0]   rd_in;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done_out;
    logic [N_REQ-1:0]   timeout_err;
    logic [7:0]         rdata;
    logic               ack_out;
    logic               m_start;
    logic [6:0]         m_device_addr;
    logic [7:0]         m_write_data;
    logic               m_read_req;
    logic               m_done;
    logic [7:0]         m_read_data;
    logic               m_ack;

    modport master (
        input  req, lock, dev_addr_in, wdata_in, rd_in, m_done, m_read_data, m_ack,
        output gnt, done_out, timeout_err, rdata, ack_out,
               m_start, m_device_addr, m_write_data, m_read_req
    );

    modport slave (
        output req, lock, dev_addr_in, wdata_in, rd_in, m_done, m_read_data, m_ack,
        input  gnt, done_out, timeout_err, rdata, ack_out,
               m_start, m_device_addr, m_write_data, m_read_req
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C master with lock bursts and watchdog
module i2c_bus_arbiter #(
    parameter int N_REQ     = 3,
    parameter int TIMEOUT   = 200000,
    parameter int MAX_BURST = 16
) (
    input logic               clk,
    input logic               rst,
    i2c_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           rd_q, rd_d;
    logic [BW-1:0]  burst_q, burst_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           to_q, to_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           ack_q, ack_d;
    logic           found;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  src;
    logic [N_REQ-1:0] onehot;

    // Round-robin search: first requester after ptr, wrapping
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req[IW'((int'(ptr_q) + k) % N_REQ)]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // Fields come from the winner on arbitration, from the owner on relatch
    assign src    = (state_q == IDLE) ? sel : owner_q;
    assign onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

    // Next-state logic: arbitration, issue, watchdog wait and burst continuation
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        burst_d = burst_q;
        timer_d = timer_q;
        to_d    = to_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = sel;
                    addr_d  = bus.dev_addr_in[7*src +: 7];
                    wdata_d = bus.wdata_in[8*src +: 8];
                    rd_d    = bus.rd_in[src];
                    burst_d = BW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                to_d    = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.m_done) begin
                    rdata_d = bus.m_read_data;
                    ack_d   = bus.m_ack;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    ack_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.lock[owner_q] && bus.req[owner_q] && burst_q < BW'(MAX_BURST)) begin
                    addr_d  = bus.dev_addr_in[7*src +: 7];
                    wdata_d = bus.wdata_in[8*src +: 8];
                    rd_d    = bus.rd_in[src];
                    burst_d = burst_q + 1'b1;
                    state_d = ISSUE;
                end else begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; ptr starts at the last requester so 0 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            burst_q <= '0;
            timer_q <= '0;
            to_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            burst_q <= burst_d;
            timer_q <= timer_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.gnt           = (state_q != IDLE) ? onehot : '0;
    assign bus.done_out      = (state_q == RESP) ? onehot : '0;
    assign bus.timeout_err   = (state_q == RESP && to_q) ? onehot : '0;
    assign bus.rdata         = rdata_q;
    assign bus.ack_out       = ack_q;
    assign bus.m_start       = (state_q == ISSUE);
    assign bus.m_device_addr = addr_q;
    assign bus.m_write_data  = wdata_q;
    assign bus.m_read_req    = rd_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: vector table plus scoreboard-checked arbitration sequences
module tb_i2c_bus_arbiter;
    localparam int TO = 10;

    typedef struct {
        int         idx;
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wd;
        logic [7:0] md;
        logic       ma;
        int         dly;
    } vec_t;

    typedef struct {
        int         own;
        logic       to;
        logic [7:0] rd;
        logic       ack;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    sb_t  q[$];
    logic [7:0] last_rd = 8'h00;
    int   ptr_m = 2;

    i2c_bus_arbiter_if #(.N_REQ(3)) bus ();

    i2c_bus_arbiter #(.N_REQ(3), .TIMEOUT(TO), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every done pulse must match the oldest expected transaction
    always @(negedge clk) begin
        if (rst && bus.done_out != 3'b000) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got %0h expected none", bus.done_out);
            end else begin
                sb_t e;
                e = q.pop_front();
                chk("sb_done", 32'(bus.done_out), oh(e.own));
                chk("sb_timeout", 32'(bus.timeout_err), e.to ? oh(e.own) : 32'(0));
                chk("sb_rdata", 32'(bus.rdata), 32'(e.rd));
                chk("sb_ack", 32'(bus.ack_out), 32'(e.ack));
            end
        end
    end

    task automatic wait_start(input int n_exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.m_start && n < 20);
        chk("start_latency", 32'(n), 32'(n_exp));
    endtask

    // Entered in the ISSUE cycle; returns in the RESP cycle
    task automatic do_txn(input int own, input int dly, input logic [7:0] md, input logic ma);
        sb_t e;
        int  cyc;
        chk("issue_gnt", 32'(bus.gnt), oh(own));
        chk("issue_start", 32'(bus.m_start), 32'(1));
        e.own = own;
        e.to  = (dly == 0);
        e.rd  = (dly == 0) ? last_rd : md;
        e.ack = (dly == 0) ? 1'b0 : ma;
        q.push_back(e);
        if (dly != 0) last_rd = md;
        bus.m_read_data = md;
        bus.m_ack = ma;
        cyc = 0;
        do begin
            bus.m_done = (dly != 0 && cyc == dly);
            tick();
            cyc++;
            if (cyc == 1) chk("wait_start_low", 32'(bus.m_start), 32'(0));
        end while (bus.done_out == 3'b000 && cyc < 40);
        bus.m_done = 1'b0;
        chk("done_latency", 32'(cyc), 32'((dly == 0) ? TO + 1 : dly + 1));
        chk("resp_gnt", 32'(bus.gnt), oh(own));
    endtask

    task automatic set_fields(input int i, input logic rd, input logic [6:0] a, input logic [7:0] w);
        bus.dev_addr_in[7*i +: 7] = a;
        bus.wdata_in[8*i +: 8] = w;
        bus.rd_in[i] = rd;
    endtask

    initial begin
        vec_t tbl[6];
        int   own;
        tbl[0] = '{0, 1'b1, 7'h68, 8'h43, 8'hA5, 1'b1, 3};
        tbl[1] = '{1, 1'b0, 7'h1E, 8'h20, 8'h3C, 1'b1, 1};
        tbl[2] = '{2, 1'b1, 7'h53, 8'h32, 8'h7E, 1'b1, 0};
        tbl[3] = '{0, 1'b1, 7'h0D, 8'hFF, 8'hC8, 1'b1, 10};
        tbl[4] = '{1, 1'b0, 7'h7F, 8'h00, 8'h11, 1'b0, 9};
        tbl[5] = '{2, 1'b1, 7'h01, 8'h80, 8'h96, 1'b1, 2};

        bus.req = '0;
        bus.lock = '0;
        bus.dev_addr_in = '0;
        bus.wdata_in = '0;
        bus.rd_in = '0;
        bus.m_done = 1'b0;
        bus.m_read_data = '0;
        bus.m_ack = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt), 32'(0));
        chk("rst_start", 32'(bus.m_start), 32'(0));
        chk("rst_rdata", 32'(bus.rdata), 32'(0));
        chk("rst_ack", 32'(bus.ack_out), 32'(0));
        chk("rst_done", 32'(bus.done_out), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            set_fields(tbl[v].idx, tbl[v].rd, tbl[v].addr, tbl[v].wd);
            bus.req = 3'(oh(tbl[v].idx));
            wait_start(1);
            chk("vec_addr", 32'(bus.m_device_addr), 32'(tbl[v].addr));
            chk("vec_wdata", 32'(bus.m_write_data), 32'(tbl[v].wd));
            chk("vec_rd", 32'(bus.m_read_req), 32'(tbl[v].rd));
            bus.req = '0;
            do_txn(tbl[v].idx, tbl[v].dly, tbl[v].md, tbl[v].ma);
            tick();
            chk("vec_release", 32'(bus.gnt), 32'(0));
            ptr_m = tbl[v].idx;
        end

        bus.m_read_data = 8'hEE;
        bus.m_ack = 1'b1;
        bus.m_done = 1'b1;
        repeat (2) tick();
        bus.m_done = 1'b0;
        chk("idle_done_rdata", 32'(bus.rdata), 32'(last_rd));
        chk("idle_done_gnt", 32'(bus.gnt), 32'(0));

        bus.req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            own = (ptr_m + 1) % 3;
            wait_start(1);
            do_txn(own, 1, 8'(8'h40 + t), 1'b1);
            ptr_m = own;
            if (t == 3) bus.req = '0;
            tick();
            chk("rr_idle_gnt", 32'(bus.gnt), 32'(0));
        end

        bus.req = 3'b011;
        bus.lock = 3'b010;
        for (int b = 0; b < 4; b++) begin
            wait_start(1);
            do_txn(1, 1, 8'(8'h50 + b), 1'b1);
        end
        wait_start(2);
        do_txn(0, 2, 8'h66, 1'b1);
        bus.req = '0;
        bus.lock = '0;
        tick();
        chk("burst_release", 32'(bus.gnt), 32'(0));

        bus.req = 3'b001;
        wait_start(1);
        bus.req = '0;
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'(0));
        chk("mid_rst_start", 32'(bus.m_start), 32'(0));
        chk("mid_rst_rdata", 32'(bus.rdata), 32'(0));
        chk("mid_rst_ack", 32'(bus.ack_out), 32'(0));
        last_rd = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        tick();
        bus.req = 3'b110;
        wait_start(1);
        bus.req = '0;
        do_txn(1, 1, 8'h9A, 1'b1);
        repeat (3) tick();
        chk("sb_drained", 32'(q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

- Shares the single `i2c_master_0` transaction port between `N_REQ` requesters (gyro reader, config writer, diagnostics).
- Arbitration is round-robin. A lock lets one requester keep the bus across back-to-back transactions, e.g. register-address write followed by data read.
- A per-transaction watchdog guards against a master that never reports `done`.
- Sits between the sensor sequencers and the I2C master; the master port connects directly to `i2c_master_0`.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `TIMEOUT`, 200000: clk cycles allowed from `m_start` to `m_done`.
- `MAX_BURST`, 16: maximum consecutive locked transactions before forced release.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester transaction request (level).
- `lock`  in  N_REQ  keep ownership after the current transaction.
- `dev_addr_in`  in  7*N_REQ  7-bit device address per requester; slice i = [7i+6:7i].
- `wdata_in`  in  8*N_REQ  write byte or register address per requester; slice i = [8i+7:8i].
- `rd_in`  in  N_REQ  1 = read transaction, 0 = write.
- `gnt`  out  N_REQ  one-hot owner indication.
- `done_out`  out  N_REQ  one-cycle completion pulse to the owner.
- `timeout_err`  out  N_REQ  one-cycle pulse; the owner's transaction timed out.
- `rdata`  out  8  last captured read byte.
- `ack_out`  out  1  last captured ack (0 on timeout).
- `m_start`  out  1  start pulse to the master.
- `m_device_addr`  out  7  device address to the master.
- `m_write_data`  out  8  write byte to the master.
- `m_read_req`  out  1  read request to the master.
- `m_done`  in  1  master completion pulse.
- `m_read_data`  in  8  master read byte.
- `m_ack`  in  1  master ack.

## Operation
- **State machine:** IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from registered state.
- **IDLE:** if any `req` bit is set, select the first set bit searching from `ptr+1` upward, wrapping modulo N_REQ.
  - Latch the owner index plus its address, data and rd fields.
  - Set `burst_cnt` = 1 and go to ISSUE.
  - `ptr` resets to N_REQ-1, so requester 0 wins first.
- **ISSUE (1 cycle):**
  - `m_start` = 1.
  - `m_device_addr`, `m_write_data` and `m_read_req` come from the latches and stay held through WAIT.
  - Clear the timer and go to WAIT.
- **WAIT:**
  - Timer increments each cycle.
  - On `m_done`: capture `m_read_data` into `rdata` and `m_ack` into `ack_out`, then go to RESP.
  - Else, if the timer reaches TIMEOUT-1: set `ack_out` = 0, keep `rdata` unchanged, flag timeout, go to RESP.
  - If `m_done` and timeout occur in the same cycle, `m_done` wins and there is no error.
- **RESP (1 cycle):**
  - `done_out[owner]` = 1. `timeout_err[owner]` = 1 if the timeout was flagged.
  - Continue if `lock[owner]` && `req[owner]` && `burst_cnt` < MAX_BURST: relatch the owner's fields, increment `burst_cnt`, go to ISSUE. There is no rearbitration.
  - Otherwise set `ptr` = owner, drop `gnt`, and go to IDLE.
- **`gnt`:** `gnt[owner]` is 1 from ISSUE through RESP inclusive. All bits are 0 in IDLE.
- **Requester rules:** fields must be stable while `req` is high. Fields are sampled at arbitration (IDLE) or at relatch (RESP).
- **Withdrawals:**
  - Deasserting `req` before grant withdraws the request.
  - Deasserting `req` while granted does not abort the transaction; the done pulse is still issued.
- **`m_done` outside WAIT** is ignored.
- **Reset** (at any time, including mid-transaction):
  - All outputs go to 0. `rdata` = 0, `ack_out` = 0.
  - State = IDLE, `ptr` = N_REQ-1, timer = 0, `burst_cnt` = 0.
  - The master shares the same reset.

## Timing
- Request high in IDLE at cycle N: `gnt` and `m_start` are high at N+1.
- `m_done` at cycle D: `done_out`, `rdata` and `ack_out` are valid at D+1.
  - `rdata` and `ack_out` hold until the next capture.
- Minimum request-to-`done_out` latency: 3 cycles (`m_done` at N+2).
- Locked back-to-back: next `m_start` comes 1 cycle after RESP, i.e. D+2.
- After release, the earliest next grant is RESP+2: one IDLE cycle of arbitration.
- Timeout: `timeout_err` asserts TIMEOUT+1 cycles after the `m_start` cycle.
- Timer width is clog2(TIMEOUT+1). `burst_cnt` width is clog2(MAX_BURST+1).

## Test plan
- **Single requester:** `req[0]` only, rd=1, addr 0x68, wdata 0x43; master returns 0xA5 with ack=1 three cycles after start.
  - Expect `m_start` at N+1 with 0x68/0x43/rd=1, `done_out[0]` at D+1, `rdata` = 0xA5, `ack_out` = 1.
- **Round-robin:** `req` = 3'b111 held, no lock, each transaction completing immediately.
  - Expect grant order 0, 1, 2, 0; each grant lasts ISSUE..RESP.
- **Lock burst:** `lock[1]` and `req[1]` held, `req[0]` also high, MAX_BURST = 4.
  - Expect 4 consecutive transactions for requester 1, then forced release and grant to 2 or 0 per `ptr` (here 0 after wrap: `ptr` = 1 gives search order 2, 0, so 0).
- **Timeout:** TIMEOUT = 10, master never asserts `m_done`.
  - Expect `timeout_err[owner]` and `done_out[owner]` together at start+11, `ack_out` = 0, `rdata` unchanged.
  - Expect the bus to be released afterwards.
- **Simultaneous done and timeout:** `m_done` on the exact timeout cycle.
  - Expect no `timeout_err`, and `rdata` = `m_read_data`.
- **Mid-transaction reset:** assert `rst` low in WAIT.
  - Expect immediate `gnt` = 0, `m_start` = 0, `rdata` = 0.
  - After release, `req` = 3'b110 grants requester 1 first.
